// File: rtl/reg_scoreboard_decoder_pkg.sv
// Shared sizing and one-hot helper for the register scoreboard and its decoders.
package reg_scoreboard_decoder_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned NREG_DEFAULT   = 1 << ADDR_W_DEFAULT;

  // Reference one-hot decode at the default width; bit i <=> address i.
  function automatic logic [NREG_DEFAULT-1:0] onehot(
    input logic [ADDR_W_DEFAULT-1:0] addr,
    input logic                      en
  );
    logic [NREG_DEFAULT-1:0] z;
    z = '0;
    if (en) z[addr] = 1'b1;
    return z;
  endfunction

endpackage

// File: rtl/reg_scoreboard_decoder_onehot_decoder.sv
// Parametrised address-to-one-hot decoder; all-zero output when en is low.
module reg_scoreboard_decoder_onehot_decoder
  import reg_scoreboard_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0]        x,
  input  logic                     en,
  output logic [(1 << ADDR_W)-1:0] z
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] z_c;

  always_comb begin
    z_c = '0;
    if (en) z_c[x] = 1'b1;
  end

  assign z = z_c;

endmodule

// File: rtl/reg_scoreboard_decoder.sv
// Register busy scoreboard: tracks issued-but-not-written-back destinations,
// stalls issue on RAW/WAW hazards and drives the register-file write enables.
module reg_scoreboard_decoder
  import reg_scoreboard_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic [ADDR_W-1:0]        issue_dst,
  input  logic [ADDR_W-1:0]        src_a,
  input  logic [ADDR_W-1:0]        src_b,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_dst,
  output logic [(1 << ADDR_W)-1:0] rf_we,
  output logic [(1 << ADDR_W)-1:0] busy_vec,
  output logic [ADDR_W:0]          outstanding,
  output logic                     wb_err
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam int unsigned CW   = ADDR_W + 1;

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic            wb_err_q, wb_err_d;

  logic [NREG-1:0] wb_oh, set_oh;
  logic [NREG-1:0] rf_we_c, set_mask_c;
  logic            busy_a_c, busy_b_c, busy_dst_c;
  logic            issue_ready_c, accept_c;

  reg_scoreboard_decoder_onehot_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
    .x  (wb_dst),
    .en (wb_valid),
    .z  (wb_oh)
  );

  reg_scoreboard_decoder_onehot_decoder #(.ADDR_W(ADDR_W)) u_set_dec (
    .x  (issue_dst),
    .en (accept_c & issue_wr),
    .z  (set_oh)
  );

  // Hazard lookup with same-cycle writeback bypass; ready is forced high in reset.
  always_comb begin
    rf_we_c = wb_oh;
    if (ZERO_HARDWIRED) rf_we_c[0] = 1'b0;
    busy_a_c      = busy_q[src_a]     & ~(wb_valid && (wb_dst == src_a));
    busy_b_c      = busy_q[src_b]     & ~(wb_valid && (wb_dst == src_b));
    busy_dst_c    = busy_q[issue_dst] & ~(wb_valid && (wb_dst == issue_dst));
    issue_ready_c = reset | ~(busy_a_c | busy_b_c | (issue_wr & busy_dst_c));
    accept_c      = issue_valid & issue_ready_c;
  end

  // Next state: set wins over a same-register writeback clear.
  always_comb begin
    set_mask_c = set_oh;
    if (ZERO_HARDWIRED) set_mask_c[0] = 1'b0;
    busy_d        = (busy_q & ~rf_we_c) | set_mask_c;
    outstanding_d = outstanding_q + CW'(|set_mask_c) - CW'(|(rf_we_c & busy_q));
    wb_err_d      = wb_err_q | (|(rf_we_c & ~busy_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($countones(busy_q) == 32'(outstanding_q))
        else $error("outstanding count diverged from busy population");
    end
  end

  assign issue_ready = issue_ready_c;
  assign rf_we       = rf_we_c;
  assign busy_vec    = busy_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
// Directed and randomized checks of the register scoreboard against a busy-set model.
module tb_reg_scoreboard_decoder;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              issue_valid = 1'b0, issue_wr = 1'b0;
  logic [ADDR_W-1:0] issue_dst = '0, src_a = '0, src_b = '0;
  logic              issue_ready;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_dst = '0;
  logic [NREG-1:0]   rf_we, busy_vec;
  logic [ADDR_W:0]   outstanding;
  logic              wb_err;

  int vectors = 0;
  int miscompares = 0;

  bit m_busy[NREG];
  bit m_err;

  always #5 clk = ~clk;

  reg_scoreboard_decoder #(.ADDR_W(ADDR_W), .ZERO_HARDWIRED(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_wr    (issue_wr),
    .issue_dst   (issue_dst),
    .src_a       (src_a),
    .src_b       (src_b),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .rf_we       (rf_we),
    .busy_vec    (busy_vec),
    .outstanding (outstanding),
    .wb_err      (wb_err)
  );

  // Reference model: a set of pending destinations plus a sticky error flag.
  function automatic bit m_pending(input logic [ADDR_W-1:0] r);
    return m_busy[r] && !(wb_valid && wb_dst == r);
  endfunction

  function automatic bit m_ready();
    if (reset) return 1'b1;
    return !(m_pending(src_a) || m_pending(src_b) || (issue_wr && m_pending(issue_dst)));
  endfunction

  function automatic logic [NREG-1:0] m_rf_we();
    logic [NREG-1:0] r;
    r = '0;
    if (wb_valid && wb_dst != 0) r = NREG'(1) << wb_dst;
    return r;
  endfunction

  function automatic logic [NREG-1:0] m_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic drive(input logic iv, input logic iw, input logic [ADDR_W-1:0] dst,
                       input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] sb,
                       input logic wv, input logic [ADDR_W-1:0] wd);
    issue_valid = iv; issue_wr = iw; issue_dst = dst;
    src_a = sa; src_b = sb; wb_valid = wv; wb_dst = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Commit the current inputs into the model, then move to just after the next edge.
  task automatic advance();
    bit acc;
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      acc = issue_valid && m_ready();
      if (wb_valid && wb_dst != 0) begin
        if (!m_busy[wb_dst]) m_err = 1'b1;
        m_busy[wb_dst] = 1'b0;
      end
      if (acc && issue_wr && issue_dst != 0) m_busy[issue_dst] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd4);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    vectors++;
    if (rf_we !== 32'h0000_0010) begin miscompares++; $display("FAIL reset_rf_we: got %h want 00000010", rf_we); end
    advance();
    idle();
    advance();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy_vec !== '0) begin miscompares++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    vectors++;
    if (outstanding !== '0) begin miscompares++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", issue_ready); end
    vectors++;
    if (rf_we !== '0) begin miscompares++; $display("FAIL idle_rf_we: got %h want 0", rf_we); end
    vectors++;
    if (wb_err !== 1'b0) begin miscompares++; $display("FAIL reset_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_raw();
    drive(1'b1, 1'b1, 5'd3, '0, '0, 1'b0, '0);
    advance();
    drive(1'b1, 1'b0, '0, 5'd3, '0, 1'b0, '0);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall: got %b want 0", issue_ready); end
    vectors++;
    if (busy_vec !== 32'h0000_0008) begin miscompares++; $display("FAIL raw_busy: got %h want 00000008", busy_vec); end
    vectors++;
    if (outstanding !== 6'd1) begin miscompares++; $display("FAIL raw_outstanding: got %0d want 1", outstanding); end
    advance();
    drive(1'b1, 1'b0, '0, 5'd3, '0, 1'b1, 5'd3);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL raw_bypass: got %b want 1", issue_ready); end
    vectors++;
    if (rf_we !== 32'h0000_0008) begin miscompares++; $display("FAIL raw_rf_we: got %h want 00000008", rf_we); end
    advance();
    idle();
    @(negedge clk);
    vectors++;
    if (busy_vec !== '0) begin miscompares++; $display("FAIL raw_cleared: got %h want 0", busy_vec); end
    vectors++;
    if (outstanding !== '0) begin miscompares++; $display("FAIL raw_count: got %0d want 0", outstanding); end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 1'b1, 5'd7, '0, '0, 1'b0, '0);
    advance();
    drive(1'b1, 1'b1, 5'd7, '0, '0, 1'b1, 5'd7);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL same_ready: got %b want 1", issue_ready); end
    vectors++;
    if (rf_we !== 32'h0000_0080) begin miscompares++; $display("FAIL same_rf_we: got %h want 00000080", rf_we); end
    advance();
    idle();
    @(negedge clk);
    vectors++;
    if (busy_vec !== 32'h0000_0080) begin miscompares++; $display("FAIL same_busy: got %h want 00000080", busy_vec); end
    vectors++;
    if (outstanding !== 6'd1) begin miscompares++; $display("FAIL same_count: got %0d want 1", outstanding); end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd7);
    advance();
    idle();
  endtask

  task automatic test_zero();
    drive(1'b1, 1'b1, 5'd0, '0, '0, 1'b0, '0);
    advance();
    drive(1'b1, 1'b0, '0, 5'd0, '0, 1'b1, 5'd0);
    @(negedge clk);
    vectors++;
    if (busy_vec !== '0) begin miscompares++; $display("FAIL zero_busy: got %h want 0", busy_vec); end
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready: got %b want 1", issue_ready); end
    vectors++;
    if (rf_we !== '0) begin miscompares++; $display("FAIL zero_rf_we: got %h want 0", rf_we); end
    advance();
    idle();
    @(negedge clk);
    vectors++;
    if (outstanding !== '0) begin miscompares++; $display("FAIL zero_count: got %0d want 0", outstanding); end
    vectors++;
    if (wb_err !== 1'b0) begin miscompares++; $display("FAIL zero_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_waw();
    drive(1'b1, 1'b1, 5'd5, '0, '0, 1'b0, '0);
    advance();
    drive(1'b1, 1'b1, 5'd5, '0, '0, 1'b0, '0);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL waw_stall: got %b want 0", issue_ready); end
    drive(1'b1, 1'b0, 5'd5, '0, '0, 1'b0, '0);
    #1;
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL waw_no_write: got %b want 1", issue_ready); end
    advance();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd5);
    advance();
    idle();
  endtask

  task automatic test_wb_err();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd9);
    advance();
    idle();
    @(negedge clk);
    vectors++;
    if (wb_err !== 1'b1) begin miscompares++; $display("FAIL wb_err_set: got %b want 1", wb_err); end
    advance();
    @(negedge clk);
    vectors++;
    if (wb_err !== 1'b1) begin miscompares++; $display("FAIL wb_err_sticky: got %b want 1", wb_err); end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k < NREG; k++) begin
      drive(1'b1, 1'b1, ADDR_W'(k), '0, '0, 1'b0, '0);
      advance();
    end
    idle();
    @(negedge clk);
    vectors++;
    if (outstanding !== 6'd31) begin miscompares++; $display("FAIL b2b_count: got %0d want 31", outstanding); end
    vectors++;
    if (busy_vec !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL b2b_busy: got %h want fffffffe", busy_vec); end
    drive(1'b1, 1'b0, '0, 5'd0, 5'd17, 1'b0, '0);
    @(negedge clk);
    vectors++;
    if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_src_b_stall: got %b want 0", issue_ready); end
  endtask

  task automatic test_reset_midop();
    reset = 1'b1;
    idle();
    advance();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy_vec !== '0 || outstanding !== '0 || wb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: got busy %h cnt %0d err %b want 0 0 0", busy_vec, outstanding, wb_err);
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd12);
    advance();
    idle();
    @(negedge clk);
    vectors++;
    if (wb_err !== 1'b1) begin miscompares++; $display("FAIL midop_dropped_wb: got %b want 1", wb_err); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] wd;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      wd = ADDR_W'($urandom);
      for (int t = 0; t < 6 && !m_busy[wd]; t++) wd = ADDR_W'($urandom);
      drive(1'($urandom), 1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
            ADDR_W'($urandom), 1'($urandom), wd);
      @(negedge clk);
      vectors++;
      if (issue_ready !== m_ready()) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", n, issue_ready, m_ready());
      end
      vectors++;
      if (rf_we !== m_rf_we()) begin
        miscompares++; $display("FAIL rand_rf_we[%0d]: got %h want %h", n, rf_we, m_rf_we());
      end
      advance();
      reset = 1'b0;
      #1;
      vectors++;
      if (busy_vec !== m_vec() || int'(outstanding) != m_count() || wb_err !== m_err) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got busy %h cnt %0d err %b want %h %0d %b",
                 n, busy_vec, outstanding, wb_err, m_vec(), m_count(), m_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_same_cycle();
    test_zero();
    test_waw();
    test_wb_err();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
